reg_dump_uart: RTL and testbench

Sequential register-file dump engine that sits directly downstream of the CPU top's debug read port. It drives `regNo`, captures the returned `val` word and serialises registers $0..$31 out of a single UART TX line, 4 bytes per register, most-significant byte first. It turns the CPU's combinational register-peek interface into a board-observable stream, so no simulator is needed to inspect architectural state.

---
 rtl/reg_dump_uart.sv | 145 ++++++++++++++
 tb/tb_reg_dump_uart.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_uart.sv
// reg_dump_uart
// Walks the CPU register file $0..$31 through its debug read port and
// streams every register out of an 8N1 UART line, 4 bytes per register,
// most-significant byte first.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   startin   synchronous active-high reset
//   start     dump request, honoured only in IDLE
//   tx_ready  downstream flow control, looked at only between bytes
//   val       register value returned by the CPU for regNo
//   regNo     register index presented to the CPU
//   tx        UART line (idle high, LSB-first data)
//   busy      dump in progress
//   done      one-cycle pulse when the last stop bit has gone out
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        start,
  input  logic        tx_ready,
  input  logic [31:0] val,
  output logic [4:0]  regNo,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, WAIT, START, DATA, STOP, DONE
  } state_t;

  state_t          state;
  logic [4:0]      reg_cnt;
  logic [1:0]      byte_cnt;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   baud;
  logic [31:0]     shift_word;
  logic [7:0]      cur_byte;
  logic            baud_end;

  assign cur_byte = shift_word[31:24];
  assign baud_end = (baud == BAUD_LAST);
  // The register counter doubles as the CPU index; it only moves on the
  // STOP->SETUP edge, so regNo is stable for a whole register's bytes.
  assign regNo    = reg_cnt;

  always_ff @(posedge clk) begin
    if (startin) begin
      state      <= IDLE;
      reg_cnt    <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      baud       <= '0;
      shift_word <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            reg_cnt <= '0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        // One dead cycle so the register file read path settles on the
        // new index before val is captured.
        SETUP: state <= LOAD;
        LOAD: begin
          shift_word <= val;
          byte_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          tx   <= 1'b1;
          baud <= '0;
          if (tx_ready) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud       <= '0;
            shift_word <= {shift_word[23:0], 8'h00};
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt != 2'd3) begin
              state <= WAIT;
            end else if (reg_cnt != 5'd31) begin
              reg_cnt <= reg_cnt + 5'd1;
              state   <= SETUP;
            end else begin
              // busy drops on the same edge done rises
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DONE: begin
          // start is deliberately ignored here
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_uart.sv
// Directed bench for reg_dump_uart at CLKS_PER_BIT=4. A UART monitor decodes
// the tx line into a byte log; the initial block drives the directed steps
// and checks that log and the control outputs against hand-derived values.
module tb_reg_dump_uart;
  localparam int C = 4;
  localparam int DUMP_LAT = 1 + 32 * (2 + 4 + 40 * C);  // 5313

  logic        clk = 1'b0;
  logic        startin, start, tx_ready;
  logic [31:0] val;
  logic [4:0]  regNo;
  logic        tx, busy, done;
  logic        mode;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  reg_dump_uart #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .startin(startin), .start(start), .tx_ready(tx_ready),
    .val(val), .regNo(regNo), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU register file model
  always_comb begin
    val = 32'h0;
    if (mode == 1'b0)
      val = {8'hA0 | {3'b000, regNo}, {3'b000, regNo}, {3'b000, regNo}, {3'b000, regNo}};
    else if (regNo == 5'd17)
      val = 32'h12345678;
  end

  // UART monitor: frame starts on first low sample, bits sampled mid-cell
  logic [7:0] bytes_q [0:255];
  logic [7:0] sh;
  int  nbytes, ndone, ferr, win_bad, done_cyc, mcnt;
  logic done_busy, done_prev_busy, prev_busy;
  bit  in_frame;

  always @(negedge clk) begin
    if (startin) begin
      in_frame = 1'b0;
      mcnt = 0;
    end else if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame = 1'b1;
        mcnt = 0;
      end
    end else begin
      mcnt++;
      for (int k = 0; k < 8; k++)
        if (mcnt == C * (k + 1) + C / 2) sh[k] = tx;
      if (mcnt == 9 * C + C / 2) begin
        if (tx !== 1'b1) ferr++;
        if (nbytes < 256) bytes_q[nbytes] = sh;
        nbytes++;
        in_frame = 1'b0;
      end
    end
    if (in_frame && nbytes >= 68 && nbytes <= 71 && regNo !== 5'd17) win_bad++;
    if (done === 1'b1) begin
      ndone++;
      done_cyc = cyc;
      done_busy = busy;
      done_prev_busy = prev_busy;
    end
    prev_busy = busy;
  end

  task automatic mon_clear();
    nbytes = 0; ndone = 0; ferr = 0; win_bad = 0; done_cyc = 0;
    done_busy = 1'b0; done_prev_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic m, input int idx);
    logic [7:0] r;
    logic [31:0] w;
    r = 8'(idx / 4);
    if (m == 1'b0) w = {8'hA0 | r, r, r, r};
    else w = (r == 8'd17) ? 32'h12345678 : 32'h0;
    return w[31 - 8 * (idx % 4) -: 8];
  endfunction

  task automatic chk_stream(input string tag, input logic m);
    chk({tag, "_nbytes"}, nbytes, 128);
    chk({tag, "_ferr"}, ferr, 0);
    for (int i = 0; i < 128; i++)
      chk($sformatf("%s_byte%0d", tag, i), bytes_q[i], exp_byte(m, i));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (ndone == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, ndone > 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int s, d;

  initial begin
    startin = 1'b1; start = 1'b0; tx_ready = 1'b1; mode = 1'b0;
    mon_clear();
    tick(); tick();
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_regNo", regNo, 0);
    startin = 1'b0;
    repeat (30) tick();
    chk("idle_tx", tx, 1); chk("idle_busy", busy, 0);
    chk("idle_done", done, 0); chk("idle_regNo", regNo, 0);
    chk("idle_nbytes", nbytes, 0);

    // Full dump, counting sequence, with start-up timing
    mon_clear(); mode = 1'b0;
    s = cyc;
    pulse_start();
    chk("t1_busy_c1", busy, 1); chk("t1_regNo_c1", regNo, 0); chk("t1_tx_c1", tx, 1);
    tick(); tick();
    chk("t1_tx_c3", tx, 1);
    tick();
    chk("t1_tx_c4", tx, 0);
    wait_done("t1", 6000);
    chk("t1_latency", done_cyc - s, DUMP_LAT);
    chk("t1_ndone", ndone, 1);
    chk("t1_busy_at_done", done_busy, 0);
    chk("t1_busy_before_done", done_prev_busy, 1);
    chk("t1_done_after", done, 0);
    chk_stream("t1", 1'b0);

    // Single non-zero register
    repeat (5) tick();
    mon_clear(); mode = 1'b1;
    s = cyc;
    pulse_start();
    wait_done("t2", 6000);
    chk("t2_latency", done_cyc - s, DUMP_LAT);
    chk("t2_b68", bytes_q[68], 8'h12); chk("t2_b69", bytes_q[69], 8'h34);
    chk("t2_b70", bytes_q[70], 8'h56); chk("t2_b71", bytes_q[71], 8'h78);
    chk("t2_regNo_window", win_bad, 0);
    chk_stream("t2", 1'b1);

    // Flow control stall before byte 6
    repeat (5) tick();
    mon_clear(); mode = 1'b0;
    s = cyc;
    pulse_start();
    while (cyc < s + 251) tick();
    chk("t3_nbytes_at_gap", nbytes, 6);
    tx_ready = 1'b0;
    while (cyc < s + 300) tick();
    chk("t3_tx_stalled", tx, 1); chk("t3_busy_stalled", busy, 1);
    chk("t3_nbytes_stalled", nbytes, 6);
    tick();
    tx_ready = 1'b1;
    wait_done("t3", 6000);
    chk("t3_latency", done_cyc - s, DUMP_LAT + 50);
    chk_stream("t3", 1'b0);

    // start during a dump and during DONE
    repeat (5) tick();
    mon_clear();
    s = cyc;
    pulse_start();
    while (cyc < s + 1000) tick();
    pulse_start();
    while (cyc < s + DUMP_LAT && cyc < s + 7000) tick();
    chk("t4_done_at_lat", done, 1); chk("t4_busy_at_lat", busy, 0);
    d = cyc;
    start = 1'b1;
    tick();
    chk("t4_ignore_in_done", busy, 0); chk("t4_done_one_cycle", done, 0);
    tick();
    start = 1'b0;
    chk("t4_accept_in_idle", busy, 1);
    chk("t4_ndone", ndone, 1);
    chk_stream("t4a", 1'b0);
    mon_clear();
    wait_done("t4b", 6000);
    chk("t4b_latency", done_cyc - (d + 1), DUMP_LAT);
    chk("t4b_ndone", ndone, 1);
    chk_stream("t4b", 1'b0);

    // Reset mid-byte, then a fresh dump
    repeat (5) tick();
    mon_clear();
    s = cyc;
    pulse_start();
    while (cyc < s + 300) tick();
    chk("t5_pre_regNo", regNo, 1);
    startin = 1'b1;
    tick();
    chk("t5_rst_tx", tx, 1); chk("t5_rst_busy", busy, 0);
    chk("t5_rst_regNo", regNo, 0); chk("t5_rst_done", done, 0);
    startin = 1'b0;
    repeat (10) tick();
    chk("t5_idle_tx", tx, 1); chk("t5_idle_busy", busy, 0);
    mon_clear();
    s = cyc;
    pulse_start();
    wait_done("t5", 6000);
    chk("t5_latency", done_cyc - s, DUMP_LAT);
    chk_stream("t5", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
